dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS phase accumulator.
- Steps a 10-bit frequency index from a start value toward a stop value, holding each point for a programmable dwell.
- Converts each index to a 28-bit tuning word with an internal sequential shift-add multiplier.
- Drives the accumulator's tuning input and the display path's frequency index.

Parameters:
- W_FREQ, 10, frequency index width
- W_TW, 28, tuning word width
- TW_STEP, 26844, tuning word per index unit (1 kHz-equivalent step)
- W_DWELL, 24, dwell counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; return to IDLE
- mode  in  1  0 = single sweep, 1 = continuous (wrap to start)
- f_start  in  W_FREQ  first index
- f_stop  in  W_FREQ  bound index
- f_step  in  W_FREQ  step magnitude; 0 treated as 1
- dwell  in  W_DWELL  cycles held per point; 0 treated as 1
- tuner  out  W_TW  applied tuning word
- freq_cur  out  W_FREQ  index of applied word
- tw_valid  out  1  one-cycle pulse when tuner/freq_cur update
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on single-sweep completion

Behaviour:
- Reset (clr high, asynchronous): state IDLE; tuner=0, freq_cur=0, tw_valid=0, busy=0, done=0; all internal registers cleared. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, MUL, APPLY, DWELL, NEXT, DONE.
- IDLE to MUL:
  - Transition on an edge with start=1 and abort=0.
  - Same edge: shadow f_start, f_stop, f_step (0→1), dwell (0→1) and mode; cur=f_start; acc=0; bit counter=0.
  - Direction flag dir_up = (f_stop >= f_start).
  - Inputs are not re-read until the next start.
- MUL:
  - Exactly W_FREQ cycles, LSB first.
  - Each cycle: if cur[i] then acc += TW_STEP << i.
  - Sum is computed at W_FREQ+17 bits, then truncated to W_TW (max 1023*26844 = 27,461,412 fits).
  - After bit W_FREQ-1, go to APPLY.
- APPLY (1 cycle):
  - Registered on exit: tuner=acc, freq_cur=cur; tw_valid high exactly the following cycle.
  - Dwell counter loaded with shadow dwell.
  - Go to DWELL.
- DWELL: decrement each cycle; on reaching 1, go to NEXT. The point is held for exactly dwell cycles.
- NEXT (1 cycle):
  - Up: nxt = cur + step at W_FREQ+1 bits. If nxt > f_stop, the end is reached.
  - Down: if cur < step or cur - step < f_stop, the end is reached.
  - Not end: cur = nxt, acc=0, go to MUL.
  - End with mode=1: cur = f_start, go to MUL.
  - End with mode=0: go to DONE.
  - f_stop is included only if reachable by whole steps.
- DONE (1 cycle): done=1, then IDLE.
- Latency: start sampled at edge E0; tuner updated at edge E0+W_FREQ+1. Point-to-point tw_valid spacing = W_FREQ + dwell + 2 cycles.
- tuner and freq_cur hold their last applied values in IDLE, after done and after abort.
- abort:
  - From any non-IDLE state, next edge goes to IDLE.
  - No tw_valid, no done; any in-progress multiply is discarded.
  - abort and start together in IDLE: abort wins, stay IDLE.
- start while busy is ignored. A start in the cycle done is high is ignored; it is accepted the next cycle in IDLE.
- tw_valid and done are never high in the same cycle.

Test Plan:
- Reset mid-DWELL of a sweep (clr pulse) → tuner=0, freq_cur=0, busy=0, no done. A fresh start then sweeps normally.
- Single up sweep with f_start=1, f_stop=4, f_step=1, dwell=3:
  - tuner = 26844, 53688, 80532, 107376.
  - tw_valid pulses 15 cycles apart; first pulse 11 cycles after start.
  - One done pulse 5 cycles after the last tw_valid.
- Single down sweep with f_start=1000, f_stop=990, f_step=4, dwell=1:
  - tuner = 26,844,000, 26,736,624, 26,629,248 (indices 1000, 996, 992).
  - No 988 point; then done.
- Boundary, f_start=f_stop=1023 → one point, tuner=27,461,412, then done.
- f_step=0 with f_start=5, f_stop=6 → indices 5, 6.
- Continuous mode with f_start=0, f_stop=2, f_step=2, dwell=2:
  - Indices repeat 0, 2, 0, 2, ... with no done.
  - A start pulse mid-sweep is ignored.
  - abort in MUL → IDLE next edge; tuner holds 53688 (index 2) or 0 (index 0); no tw_valid, no done.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Control inputs and tuning outputs exchanged between a sweep master and
// the dds_sweep_ctrl sequencer.
interface dds_sweep_ctrl_if #(
   parameter int W_FREQ  = 10,
   parameter int W_TW    = 28,
   parameter int W_DWELL = 24
);
   logic               start;
   logic               abort;
   logic               mode;
   logic [W_FREQ-1:0]  f_start;
   logic [W_FREQ-1:0]  f_stop;
   logic [W_FREQ-1:0]  f_step;
   logic [W_DWELL-1:0] dwell;
   logic [W_TW-1:0]    tuner;
   logic [W_FREQ-1:0]  freq_cur;
   logic               tw_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, abort, mode, f_start, f_stop, f_step, dwell,
      input  tuner, freq_cur, tw_valid, busy, done
   );

   modport slave (
      input  start, abort, mode, f_start, f_stop, f_step, dwell,
      output tuner, freq_cur, tw_valid, busy, done
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps a frequency index between two bounds, turns each
// index into a DDS tuning word with a serial shift-add multiply and holds it for a dwell.
module dds_sweep_ctrl #(
   parameter int W_FREQ  = 10,
   parameter int W_TW    = 28,
   parameter int TW_STEP = 26844,
   parameter int W_DWELL = 24
) (
   input  logic            clk,
   input  logic            clr,
   dds_sweep_ctrl_if.slave bus
);

   localparam int W_SUM = W_FREQ + 17;
   localparam int W_BIT = $clog2(W_FREQ);

   localparam logic [W_BIT-1:0]   LAST_BIT   = W_BIT'(W_FREQ - 1);
   localparam logic [W_BIT-1:0]   BIT_ZERO   = {W_BIT{1'b0}};
   localparam logic [W_BIT-1:0]   BIT_ONE    = {{(W_BIT-1){1'b0}}, 1'b1};
   localparam logic [W_SUM-1:0]   STEP_SEED  = W_SUM'(TW_STEP);
   localparam logic [W_SUM-1:0]   SUM_ZERO   = {W_SUM{1'b0}};
   localparam logic [W_FREQ-1:0]  FREQ_ZERO  = {W_FREQ{1'b0}};
   localparam logic [W_FREQ-1:0]  FREQ_ONE   = {{(W_FREQ-1){1'b0}}, 1'b1};
   localparam logic [W_DWELL-1:0] DWELL_ZERO = {W_DWELL{1'b0}};
   localparam logic [W_DWELL-1:0] DWELL_ONE  = {{(W_DWELL-1){1'b0}}, 1'b1};
   localparam logic [W_TW-1:0]    TW_ZERO    = {W_TW{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_APPLY = 3'd2,
      S_DWELL = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state_r,    state_s;
   logic [W_FREQ-1:0]  start_sh_r, start_sh_s;
   logic [W_FREQ-1:0]  stop_sh_r,  stop_sh_s;
   logic [W_FREQ-1:0]  step_sh_r,  step_sh_s;
   logic [W_DWELL-1:0] dwell_sh_r, dwell_sh_s;
   logic               mode_sh_r,  mode_sh_s;
   logic               dir_up_r,   dir_up_s;
   logic [W_FREQ-1:0]  cur_r,      cur_s;
   logic [W_FREQ-1:0]  mplier_r,   mplier_s;
   logic [W_SUM-1:0]   addend_r,   addend_s;
   logic [W_TW-1:0]    acc_r,      acc_s;
   logic [W_BIT-1:0]   bit_r,      bit_s;
   logic [W_DWELL-1:0] cnt_r,      cnt_s;
   logic [W_TW-1:0]    tuner_r,    tuner_s;
   logic [W_FREQ-1:0]  freq_r,     freq_s;
   logic               tw_valid_r, tw_valid_s;
   logic               busy_r,     busy_s;
   logic               done_r,     done_s;

   logic [W_SUM-1:0]   sum_s;
   logic [W_FREQ:0]    up_nxt_s;
   logic [W_FREQ-1:0]  dn_nxt_s;
   logic               end_s;

   // Partial-product sum and next-point / end-of-sweep arithmetic
   always_comb begin
      sum_s    = W_SUM'(acc_r) + addend_r;
      up_nxt_s = {1'b0, cur_r} + {1'b0, step_sh_r};
      dn_nxt_s = cur_r - step_sh_r;
      if (dir_up_r) begin
         end_s = (up_nxt_s > {1'b0, stop_sh_r});
      end else begin
         end_s = (cur_r < step_sh_r) || (dn_nxt_s < stop_sh_r);
      end
   end

   // Next-state and datapath next values; abort from any active state wins
   always_comb begin
      state_s    = state_r;
      start_sh_s = start_sh_r;
      stop_sh_s  = stop_sh_r;
      step_sh_s  = step_sh_r;
      dwell_sh_s = dwell_sh_r;
      mode_sh_s  = mode_sh_r;
      dir_up_s   = dir_up_r;
      cur_s      = cur_r;
      mplier_s   = mplier_r;
      addend_s   = addend_r;
      acc_s      = acc_r;
      bit_s      = bit_r;
      cnt_s      = cnt_r;
      tuner_s    = tuner_r;
      freq_s     = freq_r;
      tw_valid_s = 1'b0;
      done_s     = 1'b0;

      if (bus.abort && (state_r != S_IDLE)) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               // done_r still high means DONE was just left; that start is dropped
               if (bus.start && !bus.abort && !done_r) begin
                  start_sh_s = bus.f_start;
                  stop_sh_s  = bus.f_stop;
                  step_sh_s  = (bus.f_step == FREQ_ZERO) ? FREQ_ONE : bus.f_step;
                  dwell_sh_s = (bus.dwell == DWELL_ZERO) ? DWELL_ONE : bus.dwell;
                  mode_sh_s  = bus.mode;
                  dir_up_s   = (bus.f_stop >= bus.f_start);
                  cur_s      = bus.f_start;
                  mplier_s   = bus.f_start;
                  addend_s   = STEP_SEED;
                  acc_s      = TW_ZERO;
                  bit_s      = BIT_ZERO;
                  state_s    = S_MUL;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_MUL: begin
               if (mplier_r[0]) begin
                  acc_s = W_TW'(sum_s);
               end else begin
                  acc_s = acc_r;
               end
               mplier_s = mplier_r >> 1;
               addend_s = addend_r << 1;
               if (bit_r == LAST_BIT) begin
                  state_s = S_APPLY;
               end else begin
                  bit_s = bit_r + BIT_ONE;
               end
            end
            S_APPLY: begin
               tuner_s    = acc_r;
               freq_s     = cur_r;
               tw_valid_s = 1'b1;
               cnt_s      = dwell_sh_r;
               state_s    = S_DWELL;
            end
            S_DWELL: begin
               if (cnt_r <= DWELL_ONE) begin
                  state_s = S_NEXT;
               end else begin
                  cnt_s = cnt_r - DWELL_ONE;
               end
            end
            S_NEXT: begin
               if (!end_s) begin
                  if (dir_up_r) begin
                     cur_s    = up_nxt_s[W_FREQ-1:0];
                     mplier_s = up_nxt_s[W_FREQ-1:0];
                  end else begin
                     cur_s    = dn_nxt_s;
                     mplier_s = dn_nxt_s;
                  end
                  addend_s = STEP_SEED;
                  acc_s    = TW_ZERO;
                  bit_s    = BIT_ZERO;
                  state_s  = S_MUL;
               end else if (mode_sh_r) begin
                  cur_s    = start_sh_r;
                  mplier_s = start_sh_r;
                  addend_s = STEP_SEED;
                  acc_s    = TW_ZERO;
                  bit_s    = BIT_ZERO;
                  state_s  = S_MUL;
               end else begin
                  state_s = S_DONE;
               end
            end
            S_DONE: begin
               done_s  = 1'b1;
               state_s = S_IDLE;
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end

      busy_s = (state_s != S_IDLE);
   end

   // State, shadow, multiplier and output registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r    <= S_IDLE;
         start_sh_r <= FREQ_ZERO;
         stop_sh_r  <= FREQ_ZERO;
         step_sh_r  <= FREQ_ZERO;
         dwell_sh_r <= DWELL_ZERO;
         mode_sh_r  <= 1'b0;
         dir_up_r   <= 1'b0;
         cur_r      <= FREQ_ZERO;
         mplier_r   <= FREQ_ZERO;
         addend_r   <= SUM_ZERO;
         acc_r      <= TW_ZERO;
         bit_r      <= BIT_ZERO;
         cnt_r      <= DWELL_ZERO;
         tuner_r    <= TW_ZERO;
         freq_r     <= FREQ_ZERO;
         tw_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         start_sh_r <= start_sh_s;
         stop_sh_r  <= stop_sh_s;
         step_sh_r  <= step_sh_s;
         dwell_sh_r <= dwell_sh_s;
         mode_sh_r  <= mode_sh_s;
         dir_up_r   <= dir_up_s;
         cur_r      <= cur_s;
         mplier_r   <= mplier_s;
         addend_r   <= addend_s;
         acc_r      <= acc_s;
         bit_r      <= bit_s;
         cnt_r      <= cnt_s;
         tuner_r    <= tuner_s;
         freq_r     <= freq_s;
         tw_valid_r <= tw_valid_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

   assign bus.tuner    = tuner_r;
   assign bus.freq_cur = freq_r;
   assign bus.tw_valid = tw_valid_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;

endmodule
